// File: rtl/macwl_dac_sequencer.sv
// Word-line DAC sequencer: queues {code, settle} requests, drives each code,
// opens the DAC latch for LOCK_CYC cycles, then waits the settle time.
//
// Ports:
//   sys_clk, sys_rst_n    clock, async active-low reset
//   req_valid/req_ready   request handshake (req_ready is combinational)
//   req_code, req_settle  DAC code and post-lock settle cycles
//   abort                 synchronous flush of FIFO and in-flight code
//   digital_data          code to DAC (changes only on pop)
//   dac_lock_en           DAC latch enable, high only in LOCK
//   settled, done_pulse   level / one-cycle completion indications
//   busy, fifo_level      activity and queue occupancy
module macwl_dac_sequencer #(
  parameter int DATA_W     = 8,
  parameter int LOCK_CYC   = 2,
  parameter int SETTLE_W   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [DATA_W-1:0]           req_code,
  input  logic [SETTLE_W-1:0]         req_settle,
  input  logic                        abort,
  output logic [DATA_W-1:0]           digital_data,
  output logic                        dac_lock_en,
  output logic                        settled,
  output logic                        done_pulse,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [3:0] LOCK_LOAD = 4'(LOCK_CYC - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOCK,
    SETTLE,
    DONE
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]   code;
    logic [SETTLE_W-1:0] settle;
  } entry_t;

  entry_t              mem [FIFO_DEPTH];
  entry_t              head;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    count;
  logic [LVL_W-1:0]    count_n;
  state_t              state;
  state_t              state_n;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [3:0]          lock_cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  assign fifo_full  = (count == FULL_LVL);
  assign fifo_empty = (count == '0);
  assign req_ready  = !fifo_full && !abort;
  assign push       = req_valid && req_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = count;

  // Next state and pop decision; abort overrides everything.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = LOCK;
      LOCK: begin
        if (lock_cnt == '0) begin
          if (settle_cnt == '0) state_n = DONE;
          else                  state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_W'(1)) state_n = DONE;
      end
      DONE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = SETUP;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      pop     = 1'b0;
    end
  end

  // Occupancy: push and pop together leave it unchanged.
  always_comb begin
    count_n = count;
    unique case (1'b1)
      abort:         count_n = '0;
      push && !pop:  count_n = count + LVL_W'(1);
      pop && !push:  count_n = count - LVL_W'(1);
      default:       count_n = count;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  // Storage has no reset; validity is tracked by count.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= '{code: req_code, settle: req_settle};
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      digital_data <= '0;
      settle_cnt   <= '0;
      lock_cnt     <= '0;
      dac_lock_en  <= 1'b0;
      settled      <= 1'b0;
      done_pulse   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      count       <= count_n;
      busy        <= (state_n != IDLE) || (count_n != '0);
      dac_lock_en <= (state_n == LOCK);
      done_pulse  <= (state_n == DONE);
      if (abort) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        settled <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) begin
          rd_ptr       <= rd_ptr + PTR_W'(1);
          digital_data <= head.code;
          settle_cnt   <= head.settle;
          settled      <= 1'b0;
        end else if (state_n == DONE) begin
          settled <= 1'b1;
        end
        if (state == SETUP) begin
          lock_cnt <= LOCK_LOAD;
        end else if (state == LOCK && lock_cnt != '0) begin
          lock_cnt <= lock_cnt - 4'd1;
        end
        if (state == SETTLE) begin
          settle_cnt <= settle_cnt - SETTLE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_macwl_dac_sequencer.sv
// Bench for macwl_dac_sequencer: vector table, directed corner sequences,
// and random traffic against a timing-formula reference model.
module tb_macwl_dac_sequencer;

  localparam int LOCK_CYC = 2;
  localparam int DEPTH    = 4;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_code;
  logic [7:0] req_settle;
  logic       abort;
  logic [7:0] digital_data;
  logic       dac_lock_en;
  logic       settled;
  logic       done_pulse;
  logic       busy;
  logic [2:0] fifo_level;

  int checks;
  int failures;

  macwl_dac_sequencer #(
    .DATA_W(8), .LOCK_CYC(LOCK_CYC), .SETTLE_W(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_code(req_code),
    .req_settle(req_settle),
    .abort(abort),
    .digital_data(digital_data),
    .dac_lock_en(dac_lock_en),
    .settled(settled),
    .done_pulse(done_pulse),
    .busy(busy),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    abort      = 1'b0;
    req_code   = '0;
    req_settle = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] code;
    logic [7:0] settle;
    logic       ab;
    logic       rdy;
    logic [7:0] data;
    logic       lock;
    logic       done;
    logic       stl;
    logic       bsy;
    logic [2:0] lvl;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] c, logic [7:0] s,
                              logic ab, logic rdy, logic [7:0] d,
                              logic lk, logic dn, logic st, logic b,
                              logic [2:0] l);
    vec_t t;
    t = '{v, c, s, ab, rdy, d, lk, dn, st, b, l};
    return t;
  endfunction

  typedef struct {
    logic [7:0] code;
    int         settle;
  } mreq_t;

  mreq_t      mq[$];
  bit         m_job;
  int         m_pop;
  int         m_done;
  logic [7:0] m_data;
  bit         m_stl;

  vec_t tv[21];

  initial begin
    int nd;
    int idle_cnt;
    int lat;
    bit got;
    bit in_job;
    bit dpush;
    mreq_t r;
    logic [7:0] prev;
    checks   = 0;
    failures = 0;

    // Single request, settle 0, then abort during LOCK with a queue.
    tv[0]  = mk(1, 8'hA5, 3, 0, 1, 8'h00, 0, 0, 0, 1, 1);
    tv[1]  = mk(0, 8'h00, 0, 0, 1, 8'hA5, 0, 0, 0, 1, 0);
    tv[2]  = mk(0, 8'h00, 0, 0, 1, 8'hA5, 1, 0, 0, 1, 0);
    tv[3]  = mk(0, 8'h00, 0, 0, 1, 8'hA5, 1, 0, 0, 1, 0);
    tv[4]  = mk(0, 8'h00, 0, 0, 1, 8'hA5, 0, 0, 0, 1, 0);
    tv[5]  = mk(0, 8'h00, 0, 0, 1, 8'hA5, 0, 0, 0, 1, 0);
    tv[6]  = mk(0, 8'h00, 0, 0, 1, 8'hA5, 0, 0, 0, 1, 0);
    tv[7]  = mk(0, 8'h00, 0, 0, 1, 8'hA5, 0, 1, 1, 1, 0);
    tv[8]  = mk(0, 8'h00, 0, 0, 1, 8'hA5, 0, 0, 1, 0, 0);
    tv[9]  = mk(0, 8'h00, 0, 0, 1, 8'hA5, 0, 0, 1, 0, 0);
    tv[10] = mk(1, 8'h10, 0, 0, 1, 8'hA5, 0, 0, 1, 1, 1);
    tv[11] = mk(0, 8'h00, 0, 0, 1, 8'h10, 0, 0, 0, 1, 0);
    tv[12] = mk(0, 8'h00, 0, 0, 1, 8'h10, 1, 0, 0, 1, 0);
    tv[13] = mk(0, 8'h00, 0, 0, 1, 8'h10, 1, 0, 0, 1, 0);
    tv[14] = mk(0, 8'h00, 0, 0, 1, 8'h10, 0, 1, 1, 1, 0);
    tv[15] = mk(0, 8'h00, 0, 0, 1, 8'h10, 0, 0, 1, 0, 0);
    tv[16] = mk(1, 8'h20, 2, 0, 1, 8'h10, 0, 0, 1, 1, 1);
    tv[17] = mk(1, 8'h21, 2, 0, 1, 8'h20, 0, 0, 0, 1, 1);
    tv[18] = mk(1, 8'h22, 2, 0, 1, 8'h20, 1, 0, 0, 1, 2);
    tv[19] = mk(1, 8'h23, 2, 1, 0, 8'h20, 0, 0, 0, 0, 0);
    tv[20] = mk(0, 8'h00, 0, 0, 1, 8'h20, 0, 0, 0, 0, 0);

    do_reset();
    chk("rst_data", digital_data, 0);
    chk("rst_lock", dac_lock_en, 0);
    chk("rst_settled", settled, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", req_ready, 1);

    for (int i = 0; i < 21; i++) begin
      req_valid  = tv[i].v;
      req_code   = tv[i].code;
      req_settle = tv[i].settle;
      abort      = tv[i].ab;
      #1;
      chk($sformatf("vec%0d_ready", i), req_ready, tv[i].rdy);
      tick();
      chk($sformatf("vec%0d_data", i), digital_data, tv[i].data);
      chk($sformatf("vec%0d_lock", i), dac_lock_en, tv[i].lock);
      chk($sformatf("vec%0d_done", i), done_pulse, tv[i].done);
      chk($sformatf("vec%0d_settled", i), settled, tv[i].stl);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].bsy);
      chk($sformatf("vec%0d_level", i), fifo_level, tv[i].lvl);
    end
    req_valid = 1'b0;
    abort     = 1'b0;

    // Back-to-back: codes 1..4, settle 1, one done every 2+L+S cycles.
    for (int k = 0; k < 4; k++) begin
      req_valid  = 1'b1;
      req_code   = 8'(k + 1);
      req_settle = 8'd1;
      #1;
      chk("b2b_ready", req_ready, 1);
      tick();
    end
    req_valid = 1'b0;
    nd       = 0;
    idle_cnt = 0;
    for (int c = 4; c <= 24; c++) begin
      tick();
      if (done_pulse) begin
        chk("b2b_done_edge", c, 5 * (nd + 1));
        chk("b2b_code", digital_data, nd + 1);
        nd++;
      end
      if (c <= 20 && !busy) idle_cnt++;
    end
    chk("b2b_done_count", nd, 4);
    chk("b2b_no_idle", idle_cnt, 0);
    chk("b2b_busy_end", busy, 0);

    // Full FIFO refuses a push even as DONE pops an entry.
    for (int k = 0; k < 5; k++) begin
      req_valid  = 1'b1;
      req_code   = 8'(8'h31 + k);
      req_settle = 8'd1;
      tick();
    end
    chk("full_level", fifo_level, 4);
    req_code = 8'h36;
    #1;
    chk("full_ready_a", req_ready, 0);
    tick();
    chk("full_done", done_pulse, 1);
    chk("full_level_done", fifo_level, 4);
    chk("full_ready_b", req_ready, 0);
    tick();
    chk("full_pop_level", fifo_level, 3);
    chk("full_pop_data", digital_data, 8'h32);
    req_valid = 1'b0;
    abort     = 1'b1;
    tick();
    abort = 1'b0;
    chk("full_abort_level", fifo_level, 0);
    chk("full_abort_busy", busy, 0);

    // Async reset mid-SETTLE, then nominal latency afterwards.
    req_valid  = 1'b1;
    req_code   = 8'h55;
    req_settle = 8'd5;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", digital_data, 0);
    chk("arst_lock", dac_lock_en, 0);
    chk("arst_settled", settled, 0);
    chk("arst_done", done_pulse, 0);
    chk("arst_busy", busy, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_ready", req_ready, 1);
    @(negedge clk);
    rst_n      = 1'b1;
    req_valid  = 1'b1;
    req_code   = 8'hFF;
    req_settle = 8'd2;
    tick();
    req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick();
      if (done_pulse) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk("arst_latency", lat, 1 + 1 + LOCK_CYC + 2);
    chk("arst_code", digital_data, 8'hFF);

    // Random traffic against the reference model.
    do_reset();
    mq.delete();
    m_job  = 1'b0;
    m_pop  = 0;
    m_done = 0;
    m_data = '0;
    m_stl  = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      req_valid  = ($urandom_range(0, 99) < 55);
      req_code   = 8'($urandom);
      req_settle = 8'($urandom_range(0, 4));
      abort      = ($urandom_range(0, 59) == 0);
      #1;
      chk("rnd_ready", req_ready, (mq.size() < DEPTH) && !abort);
      if (abort) begin
        mq.delete();
        m_job = 1'b0;
        m_stl = 1'b0;
      end else begin
        in_job = m_job && (n <= m_done);
        dpush  = req_valid && (mq.size() < DEPTH);
        if (!in_job && mq.size() > 0) begin
          r      = mq.pop_front();
          m_job  = 1'b1;
          m_pop  = n;
          m_done = n + 1 + LOCK_CYC + r.settle;
          m_data = r.code;
          m_stl  = 1'b0;
        end
        if (dpush) mq.push_back('{code: req_code, settle: int'(req_settle)});
        if (m_job && n == m_done) m_stl = 1'b1;
      end
      prev = digital_data;
      tick();
      chk("rnd_data", digital_data, m_data);
      chk("rnd_lock", dac_lock_en,
          m_job && (n >= m_pop + 1) && (n <= m_pop + LOCK_CYC));
      chk("rnd_done", done_pulse, m_job && (n == m_done));
      chk("rnd_settled", settled, m_stl);
      chk("rnd_busy", busy, (m_job && n <= m_done) || (mq.size() > 0));
      chk("rnd_level", fifo_level, mq.size());
      chk("rnd_lock_on_change", dac_lock_en && (digital_data != prev), 0);
    end
    req_valid = 1'b0;
    abort     = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/macwl_dac_sequencer.md
# macwl_dac_sequencer

Upstream feeder for the word-line DAC interface: accepts word-line voltage codes from the array controller over a valid/ready handshake, buffers them in a small FIFO, and for each code drives `digital_data`, pulses `dac_lock_en` for a fixed window, then waits a per-request settle time before reporting the analog level as usable. It serialises code updates so the DAC latch only opens on a stable code, and gives the array controller a cycle-exact "WL settled" indication.

## Interface
- `DATA_W`, 8: code width; matches the DAC interface data width.
- `LOCK_CYC`, 2: cycles `dac_lock_en` is held high per code; legal range 1..15.
- `SETTLE_W`, 8: width of the per-request settle count.
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, minimum 2.

- `sys_clk`, in, 1: sole clock; all logic is rising-edge.
- `sys_rst_n`, in, 1: asynchronous active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: `!fifo_full && !abort`; the only combinational output.
- `req_code`, in, DATA_W: DAC code to apply.
- `req_settle`, in, SETTLE_W: settle cycles after lock; 0 is legal.
- `abort`, in, 1: synchronous flush of FIFO and in-flight sequence.
- `digital_data`, out, DATA_W: code driven to the DAC interface; registered.
- `dac_lock_en`, out, 1: DAC latch enable; registered, high only in LOCK.
- `settled`, out, 1: level; high from DONE until the next pop, abort, or reset.
- `done_pulse`, out, 1: one-cycle pulse per completed code.
- `busy`, out, 1: state != IDLE or FIFO non-empty.
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: current entry count.

## Operation
- Push on `req_valid && req_ready`; the entry stores {code, settle}. No push when full, even if a pop happens in the same cycle.
- FSM states: IDLE, SETUP, LOCK, SETTLE, DONE.
- IDLE: if FIFO non-empty, pop, load `digital_data` and the settle counter, clear `settled`, go to SETUP.
- SETUP: one cycle, so the code is stable before the latch opens. Go to LOCK and load the lock counter with LOCK_CYC-1.
- LOCK: `dac_lock_en` high; after LOCK_CYC cycles go to SETTLE, or straight to DONE if the stored settle is 0.
- SETTLE: decrement; after exactly `req_settle` cycles go to DONE.
- DONE: `done_pulse` high and `settled` set, both for this cycle. If the FIFO is non-empty, pop and go to SETUP, which gives back-to-back operation with no IDLE cycle. Otherwise go to IDLE.
- `digital_data` changes only on a pop and holds the last code otherwise, including through abort.
- Abort, sampled high at an edge:
  - FIFO emptied, state forced to IDLE, `dac_lock_en` and `settled` cleared, no `done_pulse`.
  - A request presented in the same cycle is not accepted.
  - Abort takes priority over a pop or push on the same edge.
- Reset, asynchronous and possibly mid-operation: state IDLE, FIFO empty. All registered outputs go to 0 immediately: `digital_data`, `dac_lock_en`, `settled`, `done_pulse`, `busy`, `fifo_level`. `req_ready` becomes 1 when `abort` is 0.

## Timing
- Edge E0 accepts a request into an empty, idle block.
  - E1: pop; state SETUP.
  - E2: `dac_lock_en` rises.
  - E2+LOCK_CYC: `dac_lock_en` falls.
  - E2+LOCK_CYC+S: `done_pulse` and `settled` rise.
- With LOCK_CYC=2 and S=3, `done_pulse` is high in the cycle after E7.
- `dac_lock_en` is high for exactly LOCK_CYC consecutive cycles per code. It is never high in the same cycle that `digital_data` changes.
- Back-to-back throughput is one code every 2+LOCK_CYC+S cycles: DONE, SETUP, LOCK×L, SETTLE×S.
- `fifo_level` updates at the edge following a push or pop. Simultaneous push and pop leaves it unchanged.
- `busy` falls at the same edge the state returns to IDLE with the FIFO empty.

## Test plan
- Reset then single request (code 0xA5, settle 3, LOCK_CYC=2): `digital_data`=0xA5 from E1, `dac_lock_en` high in cycles E2–E3 only, `done_pulse` one cycle after E7, `settled` stays 1, `busy` drops at the following edge.
- Settle=0 (code 0x10): `done_pulse` in the cycle immediately after `dac_lock_en` falls, with no SETTLE cycle.
- Four requests pushed on consecutive cycles, codes 0x01–0x04, settle 1:
  - `req_ready` goes low only if a fifth is offered before the first pop;
  - `done_pulse` appears every 5 cycles;
  - codes are applied in order, with no IDLE between them.
- Push into a full FIFO while a pop occurs: the request is refused (`req_ready`=0) and `fifo_level` drops by 1.
- Abort during LOCK with 2 entries queued and `req_valid` high:
  - next edge: state IDLE, `dac_lock_en`=0, `fifo_level`=0;
  - `digital_data` unchanged;
  - no `done_pulse`, request not accepted.
- Async reset asserted mid-SETTLE between clock edges: all registered outputs go to 0 without a clock edge. After release, a new request (0xFF, settle 2) completes with nominal latency.
